// File: rtl/uart_pkg.sv
// Shared types for the UART blocks: transmitter state encoding and the
// per-frame configuration captured when a word is popped.
package uart_pkg;

  localparam int DIVW_DEF = 16;

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} tx_state_t;

  typedef struct packed {
    logic [DIVW_DEF-1:0] baud_div;
    logic                parity_en;
    logic                parity_odd;
    logic                stop2;
  } uart_cfg_t;

endpackage

// File: rtl/uart_baud_gen.sv
// Bit-period counter: counts 0..D-1 with D = max(div,1), restarts on clear.
// bit_end is high during the last cycle of each bit; bit_end_nxt is its look-ahead.
module uart_baud_gen
  import uart_pkg::*;
#(
  parameter int DIVW = DIVW_DEF
) (
  input  logic            rclk,
  input  logic            rrst_n,
  input  logic            clear,
  input  logic [DIVW-1:0] div,
  output logic            bit_end,
  output logic            bit_end_nxt
);

  logic [DIVW-1:0] per;
  logic [DIVW-1:0] cnt;
  logic [DIVW-1:0] cnt_nxt;

  always_comb begin
    per         = (div == '0) ? DIVW'(1) : div;
    cnt_nxt     = (clear || (cnt >= per - DIVW'(1))) ? '0 : cnt + DIVW'(1);
    bit_end_nxt = (cnt_nxt == per - DIVW'(1));
  end

  always_ff @(posedge rclk) begin
    if (!rrst_n) begin
      cnt     <= '0;
      bit_end <= 1'b0;
    end else begin
      cnt     <= cnt_nxt;
      bit_end <= bit_end_nxt;
    end
  end

endmodule

// File: rtl/uart_tx.sv
// UART transmitter draining a first-word-fall-through FIFO read port.
// All outputs are registered from next-state values so txd/busy/frame_done line up with the FSM.
module uart_tx
  import uart_pkg::*;
#(
  parameter int DSIZE = 8,
  parameter int DIVW  = DIVW_DEF
) (
  input  logic             rclk,
  input  logic             rrst_n,
  input  logic             tx_en,
  input  logic [DIVW-1:0]  baud_div,
  input  logic             parity_en,
  input  logic             parity_odd,
  input  logic             stop2,
  input  logic [DSIZE-1:0] rdata,
  input  logic             rempty,
  output logic             rinc,
  output logic             txd,
  output logic             busy,
  output logic             frame_done
);

  localparam int BW = (DSIZE > 1) ? $clog2(DSIZE) : 1;

  tx_state_t        state, state_n;
  logic [BW-1:0]    bit_idx, bit_idx_n;
  logic             stop_idx, stop_idx_n;
  logic [DSIZE-1:0] shreg, shreg_n;
  uart_cfg_t        cfg_q, cfg_n;
  logic             par_q, par_n;
  logic             bit_end, bit_end_nxt;
  logic             stop_last, pop;
  logic             txd_d, busy_d, frame_done_d;

  // A pop is allowed from IDLE, or as a look-ahead in the final STOP cycle.
  assign stop_last = (stop_idx == cfg_q.stop2);
  assign pop       = rrst_n && tx_en && !rempty &&
                     ((state == IDLE) || ((state == STOP) && bit_end && stop_last));
  assign rinc      = pop;

  uart_baud_gen #(
    .DIVW(DIVW_DEF)
  ) u_baud (
    .rclk       (rclk),
    .rrst_n     (rrst_n),
    .clear      (pop),
    .div        (cfg_n.baud_div),
    .bit_end    (bit_end),
    .bit_end_nxt(bit_end_nxt)
  );

  always_ff @(posedge rclk) begin
    if (!rrst_n) begin
      state    <= IDLE;
      bit_idx  <= '0;
      stop_idx <= 1'b0;
    end else begin
      state    <= state_n;
      bit_idx  <= bit_idx_n;
      stop_idx <= stop_idx_n;
    end
  end

  always_ff @(posedge rclk) begin
    shreg <= shreg_n;
    cfg_q <= cfg_n;
    par_q <= par_n;
  end

  // Parity accumulates over the captured word as it shifts out, seeded with the odd flag.
  always_comb begin
    state_n    = state;
    bit_idx_n  = bit_idx;
    stop_idx_n = stop_idx;
    shreg_n    = shreg;
    cfg_n      = cfg_q;
    par_n      = par_q;
    case (state)
      IDLE: ;
      START: begin
        if (bit_end) begin
          state_n   = DATA;
          bit_idx_n = '0;
          par_n     = cfg_q.parity_odd;
        end
      end
      DATA: begin
        if (bit_end) begin
          shreg_n = shreg >> 1;
          par_n   = par_q ^ shreg[0];
          if (bit_idx == BW'(DSIZE - 1)) begin
            state_n    = cfg_q.parity_en ? PARITY : STOP;
            stop_idx_n = 1'b0;
          end else begin
            bit_idx_n = bit_idx + BW'(1);
          end
        end
      end
      PARITY: begin
        if (bit_end) begin
          state_n    = STOP;
          stop_idx_n = 1'b0;
        end
      end
      STOP: begin
        if (bit_end) begin
          if (stop_last) state_n = IDLE;
          else           stop_idx_n = 1'b1;
        end
      end
      default: state_n = IDLE;
    endcase
    if (pop) begin
      state_n  = START;
      shreg_n  = rdata;
      cfg_n    = '{baud_div: DIVW_DEF'(baud_div), parity_en: parity_en,
                   parity_odd: parity_odd, stop2: stop2};
    end
  end

  always_comb begin
    txd_d = 1'b1;
    case (state_n)
      START:   txd_d = 1'b0;
      DATA:    txd_d = shreg_n[0];
      PARITY:  txd_d = par_n;
      default: txd_d = 1'b1;
    endcase
    busy_d       = (state_n != IDLE);
    frame_done_d = (state_n == STOP) && bit_end_nxt && (stop_idx_n == cfg_n.stop2);
  end

  always_ff @(posedge rclk) begin
    if (!rrst_n) begin
      txd        <= 1'b1;
      busy       <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      txd        <= txd_d;
      busy       <= busy_d;
      frame_done <= frame_done_d;
    end
  end

endmodule

// File: tb/tb_uart_tx.sv
// Directed bench for uart_tx: a small FWFT FIFO model feeds the DUT and a
// per-cycle trace of txd/busy/frame_done/rinc is checked against hand-built frames.
module tb_uart_tx;

  localparam int DSIZE = 8;
  localparam int DIVW  = 16;
  localparam int TRN   = 4096;

  logic             rclk = 1'b0;
  logic             rrst_n = 1'b0;
  logic             tx_en = 1'b0;
  logic [DIVW-1:0]  baud_div = 16'd4;
  logic             parity_en = 1'b0;
  logic             parity_odd = 1'b0;
  logic             stop2 = 1'b0;
  logic [DSIZE-1:0] rdata;
  logic             rempty;
  logic             rinc, txd, busy, frame_done;

  uart_tx #(.DSIZE(DSIZE), .DIVW(DIVW)) dut (
    .rclk      (rclk),
    .rrst_n    (rrst_n),
    .tx_en     (tx_en),
    .baud_div  (baud_div),
    .parity_en (parity_en),
    .parity_odd(parity_odd),
    .stop2     (stop2),
    .rdata     (rdata),
    .rempty    (rempty),
    .rinc      (rinc),
    .txd       (txd),
    .busy      (busy),
    .frame_done(frame_done)
  );

  always #5 rclk = ~rclk;

  logic [7:0] fifo [0:15];
  int wr_ptr = 0;
  int rd_ptr = 0;
  int pops   = 0;

  assign rdata  = fifo[rd_ptr[3:0]];
  assign rempty = (rd_ptr == wr_ptr);

  always @(posedge rclk) begin
    if (rinc) begin
      rd_ptr <= rd_ptr + 1;
      pops   <= pops + 1;
    end
  end

  logic tr_txd  [0:TRN-1];
  logic tr_busy [0:TRN-1];
  logic tr_fd   [0:TRN-1];
  logic tr_rinc [0:TRN-1];
  int   cyc = 0;

  always @(negedge rclk) begin
    if (cyc < TRN) begin
      tr_txd[cyc]  = txd;
      tr_busy[cyc] = busy;
      tr_fd[cyc]   = frame_done;
      tr_rinc[cyc] = rinc;
    end
    cyc = cyc + 1;
  end

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge rclk);
      #2;
    end
  endtask

  task automatic push(input logic [7:0] v);
    fifo[wr_ptr[3:0]] = v;
    wr_ptr++;
  endtask

  function automatic int find_fall(input int from);
    for (int i = from; i < cyc && i < TRN; i++)
      if (tr_txd[i] === 1'b0) return i;
    return -1;
  endfunction

  // Checks one frame starting at trace index base; pbit is the hand-computed parity bit.
  task automatic check_frame(input string tag, input int base, input logic [7:0] w,
                             input int d, input logic pe, input logic pbit, input logic s2);
    int nb, len, nbusy, nfd;
    logic b;
    logic [31:0] obs, exp;
    nb  = 10 + int'(pe) + int'(s2);
    len = nb * d;
    if (base < 1 || base + len >= cyc || base + len >= TRN) begin
      chk({tag, "_found"}, 32'd0, 32'd1);
      return;
    end
    for (int k = 0; k < nb; k++) begin
      if (k == 0)            b = 1'b0;
      else if (k <= 8)       b = w[k-1];
      else if (pe && k == 9) b = pbit;
      else                   b = 1'b1;
      obs = '0;
      for (int j = 0; j < d; j++) obs = {obs[30:0], tr_txd[base + k*d + j]};
      exp = b ? ((32'd1 << d) - 32'd1) : 32'd0;
      chk($sformatf("%s_bit%0d", tag, k), obs, exp);
    end
    nbusy = 0;
    nfd   = 0;
    for (int i = base; i < base + len; i++) begin
      if (tr_busy[i] === 1'b1) nbusy++;
      if (tr_fd[i] === 1'b1)   nfd++;
    end
    chk({tag, "_busy_len"}, nbusy, len);
    chk({tag, "_fd_count"}, nfd, 1);
    chk({tag, "_fd_last"}, {31'd0, tr_fd[base + len - 1]}, 32'd1);
    chk({tag, "_rinc_lat"}, {31'd0, tr_rinc[base - 1]}, 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int s, base, p0, bad_txd, bad_rinc, bad_busy;
    bit found;
    for (int i = 0; i < 16; i++) fifo[i] = 8'h00;

    // Reset: word already queued, rinc must stay low while rrst_n=0.
    tx_en = 1'b1;
    baud_div = 16'd4;
    push(8'h55);
    tick(3);
    chk("rst_txd", {31'd0, txd}, 32'd1);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_fd", {31'd0, frame_done}, 32'd0);
    chk("rst_rinc", {31'd0, rinc}, 32'd0);

    // 0x55, D=4, no parity, 1 stop.
    s = cyc;
    p0 = pops;
    rrst_n = 1'b1;
    tick(60);
    check_frame("f55", find_fall(s), 8'h55, 4, 1'b0, 1'b0, 1'b0);
    chk("f55_pops", pops - p0, 1);

    // 0xA3, D=2, even then odd parity.
    baud_div = 16'd2;
    parity_en = 1'b1;
    parity_odd = 1'b0;
    s = cyc;
    push(8'hA3);
    tick(35);
    check_frame("a3e", find_fall(s), 8'hA3, 2, 1'b1, 1'b0, 1'b0);
    parity_odd = 1'b1;
    s = cyc;
    push(8'hA3);
    tick(35);
    check_frame("a3o", find_fall(s), 8'hA3, 2, 1'b1, 1'b1, 1'b0);

    // Back-to-back 0x01, 0x80, D=3, two stop bits.
    baud_div = 16'd3;
    parity_en = 1'b0;
    parity_odd = 1'b0;
    stop2 = 1'b1;
    s = cyc;
    p0 = pops;
    push(8'h01);
    push(8'h80);
    tick(80);
    base = find_fall(s);
    check_frame("b2b1", base, 8'h01, 3, 1'b0, 1'b0, 1'b1);
    check_frame("b2b2", (base < 0) ? -1 : base + 33, 8'h80, 3, 1'b0, 1'b0, 1'b1);
    chk("b2b_pops", pops - p0, 2);

    // Empty FIFO for 100 cycles.
    s = cyc;
    tick(100);
    bad_txd = 0;
    bad_rinc = 0;
    bad_busy = 0;
    for (int i = s; i < s + 100; i++) begin
      if (tr_txd[i] !== 1'b1)  bad_txd++;
      if (tr_rinc[i] !== 1'b0) bad_rinc++;
      if (tr_busy[i] !== 1'b0) bad_busy++;
    end
    chk("empty_txd", bad_txd, 0);
    chk("empty_rinc", bad_rinc, 0);
    chk("empty_busy", bad_busy, 0);

    // Reset during DATA bit 3 of 0x00, D=4.
    baud_div = 16'd4;
    stop2 = 1'b0;
    push(8'h00);
    found = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (txd === 1'b0) begin
        found = 1'b1;
        break;
      end
    end
    chk("mrst_start", {31'd0, found}, 32'd1);
    tick(17);
    chk("mrst_pre_txd", {31'd0, txd}, 32'd0);
    chk("mrst_pre_busy", {31'd0, busy}, 32'd1);
    rrst_n = 1'b0;
    tick();
    chk("mrst_txd", {31'd0, txd}, 32'd1);
    chk("mrst_busy", {31'd0, busy}, 32'd0);
    rrst_n = 1'b1;
    s = cyc;
    tick(50);
    bad_txd = 0;
    bad_busy = 0;
    for (int i = s; i < s + 50; i++) begin
      if (tr_txd[i] !== 1'b1)  bad_txd++;
      if (tr_busy[i] !== 1'b0) bad_busy++;
    end
    chk("mrst_idle_txd", bad_txd, 0);
    chk("mrst_idle_busy", bad_busy, 0);

    // baud_div=0 acts as 1; tx_en dropped mid-frame leaves the second word queued.
    baud_div = 16'd0;
    s = cyc;
    p0 = pops;
    push(8'hFF);
    push(8'h00);
    tick(3);
    tx_en = 1'b0;
    tick(25);
    check_frame("ff", find_fall(s), 8'hFF, 1, 1'b0, 1'b0, 1'b0);
    chk("ff_pops", pops - p0, 1);
    chk("ff_rempty", {31'd0, rempty}, 32'd0);
    chk("ff_idle_txd", {31'd0, txd}, 32'd1);
    chk("ff_idle_busy", {31'd0, busy}, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
